// File: rtl/nth_root_iter.sv
// nth_root_iter: sequential fixed-point Nth root, floor(x^(1/n)) in Q(IN_W.FRAC_W), MSB-first restoring search
module nth_root_iter #(
  parameter int IN_W    = 10,
  parameter int FRAC_W  = 10,
  parameter int MAX_EXP = 7,
  localparam int EXP_W  = $clog2(MAX_EXP + 1),
  localparam int R_W    = IN_W + FRAC_W,
  localparam int ACC_W  = R_W * MAX_EXP,
  localparam int K_W    = $clog2(R_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data_1,
  input  logic [EXP_W-1:0] in_data_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [R_W-1:0]   out_data,
  output logic             out_err
);
  localparam logic [2:0] IDLE = 3'd0, DEC = 3'd1, TRIAL = 3'd2, MUL = 3'd3, CMP = 3'd4, OUT = 3'd5;
  logic [2:0]       state;
  logic [IN_W-1:0]  x_r;
  logic [EXP_W-1:0] n_r, cnt, n_div;
  logic [R_W-1:0]   guess, trial, t_next, g_new;
  logic [ACC_W-1:0] acc, target;
  logic [K_W-1:0]   k, k_start;
  logic [7:0]       ks;
  logic             bad, special, fit;
  assign in_ready = state == IDLE;
  assign bad      = n_r == '0 || 32'(n_r) > MAX_EXP;
  assign special  = bad || x_r == '0 || n_r == EXP_W'(1);
  assign n_div    = (n_r == '0) ? EXP_W'(1) : n_r;
  // top searched bit covers ceil(IN_W/n) integer bits of the root
  assign ks       = 8'(FRAC_W) + 8'((IN_W + 32'(n_div) - 1) / 32'(n_div)) - 8'd1;
  assign k_start  = (ks > 8'(R_W - 1)) ? K_W'(R_W - 1) : K_W'(ks);
  assign target   = ACC_W'(x_r) << (FRAC_W * 32'(n_r));
  assign t_next   = guess | (R_W'(1) << k);
  assign fit      = acc <= target;
  assign g_new    = fit ? trial : guess;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_r       <= '0;
      n_r       <= '0;
      cnt       <= '0;
      guess     <= '0;
      trial     <= '0;
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          x_r   <= in_data_1;
          n_r   <= in_data_2;
          state <= DEC;
        end
        DEC: begin
          guess     <= '0;
          k         <= k_start;
          state     <= special ? OUT : TRIAL;
          out_valid <= special;
          out_err   <= bad;
          out_data  <= (!bad && n_r == EXP_W'(1)) ? {x_r, FRAC_W'(0)} : '0;
        end
        TRIAL: begin
          trial <= t_next;
          acc   <= ACC_W'(t_next);
          cnt   <= EXP_W'(1);
          state <= MUL;
        end
        MUL: begin
          acc <= acc * ACC_W'(trial);
          cnt <= cnt + EXP_W'(1);
          if (cnt == n_r - EXP_W'(1)) state <= CMP;
        end
        CMP: begin
          guess <= g_new;
          if (acc == target || k == '0) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= g_new;
          end else begin
            k     <= k - K_W'(1);
            state <= TRIAL;
          end
        end
        OUT: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nth_root_iter.sv
// tb_nth_root_iter: directed and randomised checks of nth_root_iter against a floating-point-seeded exact floor model
module tb_nth_root_iter;
  logic        clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [9:0]  in_data_1;
  logic [2:0]  in_data_2;
  logic [19:0] out_data;
  int checks = 0, failures = 0, lat;

  nth_root_iter dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_1(in_data_1), .in_data_2(in_data_2), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] pw(longint c, int n);
    logic [159:0] p = 160'd1;
    for (int i = 0; i < n; i++) p = p * 160'(c);
    return p;
  endfunction

  // float estimate, then corrected with exact integer powers
  function automatic logic [19:0] model(int x, int n);
    logic [159:0] t;
    longint g;
    if (n == 0 || x == 0) return 20'd0;
    t = 160'(x) << (10 * n);
    g = longint'($rtoi((real'(x) ** (1.0 / real'(n))) * 1024.0));
    if (g > 1048575) g = 1048575;
    while (g < 1048575 && pw(g + 1, n) <= t) g++;
    while (g > 0 && pw(g, n) > t) g--;
    return 20'(g);
  endfunction

  task automatic send(int x, int n);
    int t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data_1 = 10'(x); in_data_2 = 3'(n);
    @(negedge clk);
    in_valid = 1'b0; in_data_1 = 10'($urandom); in_data_2 = 3'($urandom);
  endtask

  task automatic recv(string tag, logic [19:0] exp_d, logic exp_e, int gap, output int l);
    logic [19:0] d0;
    l = 0;
    while (!out_valid && l < 1000) begin @(negedge clk); l++; end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    d0 = out_data;
    repeat (gap) begin
      @(negedge clk);
      check({tag, "_hold"}, {11'd0, out_valid, out_data}, {11'd1, d0});
      check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    end
    check({tag, "_data"}, {12'd0, out_data}, {12'd0, exp_d});
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retire"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data_1 = '0; in_data_2 = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {10'd0, in_ready, out_valid, out_err, out_data}, {10'd0, 3'b100, 20'd0});
    rst = 1'b0;
    @(negedge clk);
    send(4, 2);   recv("sq4", 20'h00800, 1'b0, 0, lat);
    check("sq4_early_exit", {31'd0, lat <= 13}, 32'd1);
    send(2, 2);   recv("sq2", 20'h005A8, 1'b0, 1, lat);
    send(10, 3);  out_ready = 1'b1;
    recv("cb10", 20'h0089E, 1'b0, 0, lat);
    send(1023, 1); check("n1_lat_mid", {31'd0, out_valid}, 32'd0);
    recv("n1", 20'hFFC00, 1'b0, 0, lat);
    check("n1_lat", lat, 32'd1);
    send(5, 0);   recv("n0", 20'h0, 1'b1, 0, lat);
    check("n0_lat", lat, 32'd1);
    send(0, 7);   recv("x0", 20'h0, 1'b0, 5, lat);
    // retire and offer a new operand in the same cycle
    send(9, 2);
    while (!out_valid && lat < 1000) begin @(negedge clk); lat++; end
    check("sq9_data", {12'd0, out_data}, 32'h00C00);
    in_valid = 1'b1; in_data_1 = 10'd8; in_data_2 = 3'd3; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("overlap_idle", {30'd0, out_valid, in_ready}, 32'd1);
    send(8, 3);   recv("cb8", 20'h00800, 1'b0, 0, lat);
    // reset in the middle of a multiply sequence
    send(1000, 5);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("midrst", {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin @(negedge clk); check("midrst_quiet", {31'd0, out_valid}, 32'd0); end
    send(1000, 5); recv("r5", model(1000, 5), 1'b0, 0, lat);
    check("r5_model", {12'd0, model(1000, 5)}, 32'd4076);
    for (int i = 0; i < 30; i++) begin
      int x, n;
      x = int'($urandom_range(0, 1023));
      n = int'($urandom_range(1, 7));
      send(x, n);
      recv("rnd", model(x, n), 1'b0, int'($urandom_range(0, 3)), lat);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
